// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the MDU opcode encoding (also used by the E-stage control decoder),
// the default busy-cycle counts and a small helper that classifies opcodes.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // True for the four opcodes that launch a multi-cycle operation.
  function automatic logic mdu_is_start(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit.
// The 64-bit result is computed behaviourally in the start cycle and parked in
// a temporary {hi,lo} pair; a down-counter models the fixed latency and the
// architectural HI/LO registers only take the result when the counter expires.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   E_MDUOp   MDU opcode (mdu_pkg encoding)
//   E_A/E_B   forwarded rs / rt operands
//   E_Start   combinational, opcode is mult/multu/div/divu
//   E_Busy    high while an operation is in flight
//   E_HI/E_LO architectural HI/LO registers
//   E_MDUOut  HI for MFHI, LO for MFLO, otherwise 0
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MDUOut
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo;
  logic [31:0]      tmp_hi, tmp_lo;
  logic             div_zero;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        result;
  logic               is_div;

  // Signed divide done on magnitudes so that 0x80000000 / -1 never reaches a
  // native signed division; the quotient simply wraps to 0x80000000.
  // Returns {remainder, quotient}.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic [31:0] ua, ub, q, r;
    ua = a[31] ? (32'd0 - a) : a;
    ub = b[31] ? (32'd0 - b) : b;
    q  = (ub == 32'd0) ? 32'd0 : ua / ub;
    r  = (ub == 32'd0) ? 32'd0 : ua % ub;
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31])         r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  assign prod_s = $signed(E_A) * $signed(E_B);
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};
  assign is_div = (E_MDUOp == MDU_DIV) || (E_MDUOp == MDU_DIVU);

  always_comb begin
    result = 64'd0;
    case (E_MDUOp)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = div_signed(E_A, E_B);
      MDU_DIVU:  result = div_unsigned(E_A, E_B);
      default:   result = 64'd0;
    endcase
  end

  assign E_Start = mdu_is_start(E_MDUOp);
  assign E_Busy  = (cnt != '0);
  assign E_HI    = hi;
  assign E_LO    = lo;

  always_comb begin
    E_MDUOut = 32'd0;
    case (E_MDUOp)
      MDU_MFHI: E_MDUOut = hi;
      MDU_MFLO: E_MDUOut = lo;
      default:  E_MDUOut = 32'd0;
    endcase
  end

  // Any opcode seen while busy is dropped; the hazard unit keeps them out anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      tmp_hi   <= 32'd0;
      tmp_lo   <= 32'd0;
      div_zero <= 1'b0;
    end else if (!E_Busy) begin
      if (E_Start) begin
        tmp_hi   <= result[63:32];
        tmp_lo   <= result[31:0];
        cnt      <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        div_zero <= is_div && (E_B == 32'd0);
      end else if (E_MDUOp == MDU_MTHI) begin
        hi <= E_A;
      end else if (E_MDUOp == MDU_MTLO) begin
        lo <= E_A;
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      // Commit on the last busy edge unless the divisor was zero.
      if (cnt == CNT_W'(1) && !div_zero) begin
        hi <= tmp_hi;
        lo <= tmp_lo;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: randomized and directed operations checked against a
// 64-bit integer reference model of HI/LO.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  op = MDU_NONE;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        E_Start, E_Busy;
  logic [31:0] E_HI, E_LO, E_MDUOut;

  int total = 0;
  int bad = 0;

  // reference architectural state
  logic [31:0] mh = 32'd0;
  logic [31:0] ml = 32'd0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_MDUOp(op), .E_A(a), .E_B(b),
    .E_Start(E_Start), .E_Busy(E_Busy), .E_HI(E_HI), .E_LO(E_LO),
    .E_MDUOut(E_MDUOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: plain 64-bit integer arithmetic on the operand values.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    longint unsigned ux, uy, up;
    logic [63:0] bits;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    case (o)
      MDU_MULT:  begin p = sx * sy; bits = p; mh = bits[63:32]; ml = bits[31:0]; end
      MDU_MULTU: begin up = ux * uy; bits = up; mh = bits[63:32]; ml = bits[31:0]; end
      MDU_DIV: if (y != 0) begin
        q = sx / sy; r = sx % sy;
        bits = q; ml = bits[31:0];
        bits = r; mh = bits[31:0];
      end
      MDU_DIVU: if (y != 0) begin ml = 32'(ux / uy); mh = 32'(ux % uy); end
      MDU_MTHI: mh = x;
      MDU_MTLO: ml = x;
      default: ;
    endcase
  endtask

  function automatic int lat(input logic [3:0] o);
    return (o == MDU_DIV || o == MDU_DIVU) ? DC : MC;
  endfunction

  task automatic test_reset();
    op = MDU_NONE; reset = 1'b0;
    #12;
    total++; if (E_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", E_Busy); end
    total++; if (E_HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", E_HI); end
    total++; if (E_LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", E_LO); end
    total++; if (E_Start !== 1'b0 || E_MDUOut !== 32'd0) begin
      bad++; $display("FAIL reset_comb start=%0b out=%h want 0/0", E_Start, E_MDUOut);
    end
    @(negedge clk); reset = 1'b1;
    mh = 0; ml = 0;
  endtask

  task automatic test_arith();
    logic [3:0]  c_op [20];
    logic [31:0] c_a [20];
    logic [31:0] c_b [20];
    c_op[0] = MDU_MULT;  c_a[0] = 32'hFFFFFFFD; c_b[0] = 32'd5;
    c_op[1] = MDU_MULTU; c_a[1] = 32'hFFFFFFFD; c_b[1] = 32'd5;
    c_op[2] = MDU_DIV;   c_a[2] = 32'hFFFFFFF9; c_b[2] = 32'd2;
    c_op[3] = MDU_DIVU;  c_a[3] = 32'd7;        c_b[3] = 32'd2;
    c_op[4] = MDU_DIV;   c_a[4] = 32'h80000000; c_b[4] = 32'hFFFFFFFF;
    c_op[5] = MDU_DIV;   c_a[5] = 32'd7;        c_b[5] = 32'hFFFFFFFE;
    for (int i = 6; i < 20; i++) begin
      c_op[i] = 4'(1 + $urandom_range(0, 3));
      c_a[i]  = $urandom;
      c_b[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ((c_op[i] == MDU_DIV || c_op[i] == MDU_DIVU) && c_b[i] == 0) c_b[i] = 32'd3;
    end
    for (int i = 0; i < 20; i++) begin
      logic [31:0] old_hi, old_lo;
      int n, bc;
      bit held;
      old_hi = mh; old_lo = ml;
      n = lat(c_op[i]); bc = 0; held = 1'b1;
      @(negedge clk);
      op = c_op[i]; a = c_a[i]; b = c_b[i];
      #1;
      total++; if (E_Start !== 1'b1) begin bad++; $display("FAIL start_%0d got=%0b want=1", i, E_Start); end
      model_apply(c_op[i], c_a[i], c_b[i]);
      for (int k = 0; k < n + 4; k++) begin
        @(negedge clk);
        if (E_Busy === 1'b1) begin
          bc++;
          if (E_HI !== old_hi || E_LO !== old_lo) held = 1'b0;
        end
        op = MDU_NONE; a = $urandom; b = $urandom;
      end
      total++; if (!held) begin bad++; $display("FAIL hold_%0d hi/lo changed during busy", i); end
      total++; if (bc != n) begin bad++; $display("FAIL busy_len_%0d got=%0d want=%0d", i, bc, n); end
      total++; if (E_HI !== mh) begin bad++; $display("FAIL hi_%0d op=%0d a=%h b=%h got=%h want=%h", i, c_op[i], c_a[i], c_b[i], E_HI, mh); end
      total++; if (E_LO !== ml) begin bad++; $display("FAIL lo_%0d op=%0d a=%h b=%h got=%h want=%h", i, c_op[i], c_a[i], c_b[i], E_LO, ml); end
      op = MDU_MFHI; #1;
      total++; if (E_MDUOut !== mh) begin bad++; $display("FAIL mfhi_%0d got=%h want=%h", i, E_MDUOut, mh); end
      op = MDU_MFLO; #1;
      total++; if (E_MDUOut !== ml) begin bad++; $display("FAIL mflo_%0d got=%h want=%h", i, E_MDUOut, ml); end
      op = MDU_NONE;
    end
  endtask

  task automatic test_div_zero();
    logic [3:0] zop [2];
    zop[0] = MDU_DIV; zop[1] = MDU_DIVU;
    for (int j = 0; j < 2; j++) begin
      int bc;
      @(negedge clk); op = MDU_MTHI; a = 32'h11; model_apply(MDU_MTHI, 32'h11, 0);
      @(negedge clk); op = MDU_MTLO; a = 32'h22; model_apply(MDU_MTLO, 32'h22, 0);
      @(negedge clk); op = zop[j]; a = 32'd5; b = 32'd0;
      bc = 0;
      for (int k = 0; k < DC + 4; k++) begin
        @(negedge clk);
        if (E_Busy === 1'b1) bc++;
        op = MDU_NONE;
      end
      total++; if (bc != DC) begin bad++; $display("FAIL dz_busy_%0d got=%0d want=%0d", j, bc, DC); end
      total++; if (E_HI !== 32'h11 || E_LO !== 32'h22) begin
        bad++; $display("FAIL dz_keep_%0d got hi=%h lo=%h want 11/22", j, E_HI, E_LO);
      end
    end
  endtask

  task automatic test_mt_mf();
    logic [31:0] v;
    @(negedge clk); op = MDU_MTHI; a = 32'h1234; #1;
    total++; if (E_Start !== 1'b0) begin bad++; $display("FAIL mthi_start got=%0b want=0", E_Start); end
    model_apply(MDU_MTHI, 32'h1234, 0);
    @(negedge clk); op = MDU_MFLO; #1;
    total++; if (E_HI !== 32'h1234 || E_Busy !== 1'b0) begin bad++; $display("FAIL mthi got=%h busy=%0b want=1234/0", E_HI, E_Busy); end
    total++; if (E_MDUOut !== ml) begin bad++; $display("FAIL mflo_after_mthi got=%h want=%h", E_MDUOut, ml); end
    op = MDU_MFHI; #1;
    total++; if (E_MDUOut !== 32'h1234) begin bad++; $display("FAIL mfhi_1234 got=%h want=1234", E_MDUOut); end
    v = $urandom;
    @(negedge clk); op = MDU_MTLO; a = v; model_apply(MDU_MTLO, v, 0);
    @(negedge clk); op = 4'hF; a = $urandom; #1;
    total++; if (E_LO !== v) begin bad++; $display("FAIL mtlo got=%h want=%h", E_LO, v); end
    total++; if (E_Start !== 1'b0 || E_MDUOut !== 32'd0) begin bad++; $display("FAIL undef_comb start=%0b out=%h want 0/0", E_Start, E_MDUOut); end
    @(negedge clk); op = MDU_NONE; #1;
    total++; if (E_HI !== mh || E_LO !== ml || E_Busy !== 1'b0) begin
      bad++; $display("FAIL undef_nochange hi=%h lo=%h busy=%0b want %h/%h/0", E_HI, E_LO, E_Busy, mh, ml);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] x, y;
    int bc;
    x = $urandom; y = $urandom;
    @(negedge clk); op = MDU_MULT; a = x; b = y;
    model_apply(MDU_MULT, x, y);
    bc = 0;
    for (int k = 0; k < MC + 4; k++) begin
      @(negedge clk);
      if (E_Busy === 1'b1) bc++;
      op = MDU_NONE;
      if (E_Busy === 1'b1) begin
        if (bc == 2) begin op = MDU_MTLO; a = 32'hDEAD; end
        if (bc == 3) begin op = MDU_DIV;  a = 32'd100; b = 32'd7; end
        if (bc == 4) begin op = MDU_MTHI; a = 32'hBEEF; end
      end
    end
    total++; if (bc != MC) begin bad++; $display("FAIL ign_busy got=%0d want=%0d", bc, MC); end
    total++; if (E_HI !== mh || E_LO !== ml) begin
      bad++; $display("FAIL ign_result got hi=%h lo=%h want %h/%h", E_HI, E_LO, mh, ml);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bop [3];
    bop[0] = MDU_MULTU; bop[1] = MDU_DIV; bop[2] = MDU_MULT;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      logic [31:0] x, y;
      int bc;
      bit done;
      x = $urandom; y = $urandom | 32'd1;
      op = bop[j]; a = x; b = y;
      model_apply(bop[j], x, y);
      bc = 0; done = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (E_Busy === 1'b1) bc++;
        else begin done = 1'b1; break; end
        op = MDU_NONE;
      end
      total++; if (!done || bc != lat(bop[j])) begin bad++; $display("FAIL b2b_busy_%0d got=%0d want=%0d", j, bc, lat(bop[j])); end
      total++; if (E_HI !== mh || E_LO !== ml) begin
        bad++; $display("FAIL b2b_result_%0d got hi=%h lo=%h want %h/%h", j, E_HI, E_LO, mh, ml);
      end
    end
    op = MDU_NONE;
  endtask

  task automatic test_reset_midop();
    int bc;
    bit clean;
    @(negedge clk); op = MDU_MTHI; a = 32'hA5A5;
    @(negedge clk); op = MDU_DIV; a = 32'd1000; b = 32'd7;
    bc = 0;
    while (bc < 4) begin
      @(negedge clk);
      op = MDU_NONE;
      if (E_Busy === 1'b1) bc++; else bc = 99;
    end
    total++; if (bc != 4) begin bad++; $display("FAIL rst_mid_setup busy dropped early"); end
    #2 reset = 1'b0; #1;
    total++; if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
      bad++; $display("FAIL rst_mid busy=%0b hi=%h lo=%h want 0/0/0", E_Busy, E_HI, E_LO);
    end
    mh = 0; ml = 0;
    @(negedge clk); reset = 1'b1;
    clean = 1'b1;
    for (int k = 0; k < DC + 4; k++) begin
      @(negedge clk);
      if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) clean = 1'b0;
    end
    total++; if (!clean) begin bad++; $display("FAIL rst_late_commit hi=%h lo=%h busy=%0b want 0/0/0", E_HI, E_LO, E_Busy); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div_zero();
    test_mt_mf();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
